// File: rtl/armleocpu_regfile_arbiter_pkg.sv
// Shared definitions for the register-file arbiter: state encodings and bus widths
// used by the arbiter, its debug interface and anything that talks to either.
package armleocpu_regfile_arbiter_pkg;

   localparam int ARMLEOCPU_RFARB_ADDR_W = 5;
   localparam int ARMLEOCPU_RFARB_DATA_W = 32;

   localparam logic [1:0] ARMLEOCPU_RFARB_STATE_IDLE   = 2'd0;
   localparam logic [1:0] ARMLEOCPU_RFARB_STATE_DRAIN  = 2'd1;
   localparam logic [1:0] ARMLEOCPU_RFARB_STATE_ACCESS = 2'd2;
   localparam logic [1:0] ARMLEOCPU_RFARB_STATE_RESP   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = ARMLEOCPU_RFARB_STATE_IDLE,
      ST_DRAIN  = ARMLEOCPU_RFARB_STATE_DRAIN,
      ST_ACCESS = ARMLEOCPU_RFARB_STATE_ACCESS,
      ST_RESP   = ARMLEOCPU_RFARB_STATE_RESP
   } rfarb_state_t;

   typedef logic [ARMLEOCPU_RFARB_ADDR_W-1:0] rf_addr_t;
   typedef logic [ARMLEOCPU_RFARB_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/armleocpu_regfile_arbiter_if.sv
// Debug register-access channel: the debugger (master) raises a request and holds
// it until the arbiter (slave) returns a one-cycle ack with error flag and read data.
interface armleocpu_regfile_arbiter_if;
   import armleocpu_regfile_arbiter_pkg::*;

   logic     dbg_req;
   logic     dbg_write;
   rf_addr_t dbg_addr;
   rf_data_t dbg_wdata;
   logic     dbg_ack;
   logic     dbg_err;
   rf_data_t dbg_rdata;

   modport master (
      output dbg_req, dbg_write, dbg_addr, dbg_wdata,
      input  dbg_ack, dbg_err, dbg_rdata
   );

   modport slave (
      input  dbg_req, dbg_write, dbg_addr, dbg_wdata,
      output dbg_ack, dbg_err, dbg_rdata
   );

endinterface

// File: rtl/armleocpu_regfile_arbiter.sv
// Shares the register-file ports between the pipeline and a debug agent: stalls issue,
// waits for in-flight work to drain, then performs one debug read or write.
module armleocpu_regfile_arbiter
   import armleocpu_regfile_arbiter_pkg::*;
#(
   parameter int DRAIN_TIMEOUT = 255
) (
   input  logic     clk,
   input  logic     rst_n,

   input  logic     pipe_busy,
   output logic     pipe_hold,

   input  logic     dec_rs1_read,
   input  rf_addr_t dec_rs1_raddr,
   input  logic     dec_rs2_read,
   input  rf_addr_t dec_rs2_raddr,

   input  logic     wb_rd_write,
   input  rf_addr_t wb_rd_waddr,
   input  rf_data_t wb_rd_wdata,

   armleocpu_regfile_arbiter_if.slave dbg,

   output logic     rf_rs1_read,
   output rf_addr_t rf_rs1_raddr,
   input  rf_data_t rf_rs1_rdata,
   output logic     rf_rs2_read,
   output rf_addr_t rf_rs2_raddr,
   input  rf_data_t rf_rs2_rdata,

   output logic     rf_rd_write,
   output rf_addr_t rf_rd_waddr,
   output rf_data_t rf_rd_wdata
);

   localparam int CNT_W = (DRAIN_TIMEOUT < 1) ? 1 : $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

   rfarb_state_t     state, state_next;
   logic [CNT_W-1:0] drain_cnt;
   logic             resp_err, resp_err_next;
   logic             resp_read, resp_read_next;

   // Debug reads only ever use the rs1 port.
   logic rs2_rdata_unused;
   assign rs2_rdata_unused = ^rf_rs2_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
         resp_err  <= 1'b0;
         resp_read <= 1'b0;
      end else begin
         state     <= state_next;
         resp_err  <= resp_err_next;
         resp_read <= resp_read_next;
         // Held at zero outside DRAIN so every DRAIN entry starts counting from 0.
         if (state != ST_DRAIN)
            drain_cnt <= '0;
         else if (drain_cnt != CNT_MAX)
            drain_cnt <= drain_cnt + 1'b1;
      end
   end

   always_comb begin
      state_next     = state;
      resp_err_next  = 1'b0;
      resp_read_next = 1'b0;
      pipe_hold      = (state != ST_IDLE);

      rf_rs1_read  = dec_rs1_read;
      rf_rs1_raddr = dec_rs1_raddr;
      rf_rs2_read  = dec_rs2_read;
      rf_rs2_raddr = dec_rs2_raddr;
      rf_rd_write  = wb_rd_write;
      rf_rd_waddr  = wb_rd_waddr;
      rf_rd_wdata  = wb_rd_wdata;

      unique case (state)
         ST_IDLE: begin
            if (dbg.dbg_req)
               state_next = ST_DRAIN;
         end

         ST_DRAIN: begin
            // Timeout wins over a drain that happens to complete on the same cycle.
            if (!dbg.dbg_req) begin
               state_next = ST_IDLE;
            end else if (drain_cnt == CNT_LAST) begin
               state_next    = ST_RESP;
               resp_err_next = 1'b1;
            end else if (!pipe_busy && !wb_rd_write) begin
               state_next = ST_ACCESS;
            end
         end

         ST_ACCESS: begin
            rf_rs1_read  = 1'b0;
            rf_rs1_raddr = dbg.dbg_addr;
            rf_rs2_read  = 1'b0;
            rf_rs2_raddr = '0;
            // A late writeback keeps the rd port this cycle; the debug action waits.
            if (!wb_rd_write) begin
               rf_rs1_read    = !dbg.dbg_write;
               rf_rd_write    = dbg.dbg_write && (dbg.dbg_addr != '0);
               rf_rd_waddr    = dbg.dbg_addr;
               rf_rd_wdata    = dbg.dbg_wdata;
               resp_read_next = !dbg.dbg_write;
               state_next     = ST_RESP;
            end
         end

         ST_RESP: begin
            rf_rs1_read  = 1'b0;
            rf_rs1_raddr = dbg.dbg_addr;
            rf_rs2_read  = 1'b0;
            rf_rs2_raddr = '0;
            state_next   = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Read data arrives from the register file during RESP, one cycle after ACCESS.
   assign dbg.dbg_ack   = (state == ST_RESP);
   assign dbg.dbg_err   = (state == ST_RESP) && resp_err;
   assign dbg.dbg_rdata = ((state == ST_RESP) && resp_read) ? rf_rs1_rdata : '0;

endmodule

// File: tb/tb_armleocpu_regfile_arbiter.sv
// Randomised bench for the register-file arbiter: a golden register array predicts
// every debug response, and a monitor pops and checks each ack as it appears.
module tb_armleocpu_regfile_arbiter;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_init = 1'b1;
   logic        pipe_busy, pipe_hold;
   logic        dec_rs1_read, dec_rs2_read;
   logic [4:0]  dec_rs1_raddr, dec_rs2_raddr;
   logic        wb_rd_write;
   logic [4:0]  wb_rd_waddr;
   logic [31:0] wb_rd_wdata;
   logic        rf_rs1_read, rf_rs2_read, rf_rd_write;
   logic [4:0]  rf_rs1_raddr, rf_rs2_raddr, rf_rd_waddr;
   logic [31:0] rf_rs1_rdata, rf_rs2_rdata, rf_rd_wdata;

   always #5 clk = ~clk;

   armleocpu_regfile_arbiter_if dbg_bus();

   armleocpu_regfile_arbiter #(.DRAIN_TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_busy(pipe_busy), .pipe_hold(pipe_hold),
      .dec_rs1_read(dec_rs1_read), .dec_rs1_raddr(dec_rs1_raddr),
      .dec_rs2_read(dec_rs2_read), .dec_rs2_raddr(dec_rs2_raddr),
      .wb_rd_write(wb_rd_write), .wb_rd_waddr(wb_rd_waddr), .wb_rd_wdata(wb_rd_wdata),
      .dbg(dbg_bus),
      .rf_rs1_read(rf_rs1_read), .rf_rs1_raddr(rf_rs1_raddr), .rf_rs1_rdata(rf_rs1_rdata),
      .rf_rs2_read(rf_rs2_read), .rf_rs2_raddr(rf_rs2_raddr), .rf_rs2_rdata(rf_rs2_rdata),
      .rf_rd_write(rf_rd_write), .rf_rd_waddr(rf_rd_waddr), .rf_rd_wdata(rf_rd_wdata)
   );

   function automatic logic [31:0] init_val(int i);
      return (i == 0) ? 32'h0 : (32'hA500_0000 | (32'(i) * 32'h0001_0101));
   endfunction

   // Register-file environment: one-cycle synchronous read, write on the clock edge.
   logic [31:0] rf_mem [32];
   logic [31:0] rs1_q, rs2_q;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
         rs1_q <= 32'h0;
         rs2_q <= 32'h0;
      end else begin
         if (rf_rd_write) rf_mem[rf_rd_waddr] <= rf_rd_wdata;
         if (rf_rs1_read) rs1_q <= rf_mem[rf_rs1_raddr];
         if (rf_rs2_read) rs2_q <= rf_mem[rf_rs2_raddr];
      end
   end
   assign rf_rs1_rdata = rs1_q;
   assign rf_rs2_rdata = rs2_q;

   // Reference: architectural register contents as the debugger should see them.
   logic [31:0] golden [32];

   typedef struct { logic err; logic [31:0] rdata; } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;
   int compared = 0;
   int mismatched = 0;
   int x0_writes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && dbg_bus.dbg_ack) begin
         if (exp_q.size() == 0) begin
            check("unexpected_ack", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("ack_err", {31'd0, dbg_bus.dbg_err}, {31'd0, mon_e.err});
            check("ack_rdata", dbg_bus.dbg_rdata, mon_e.rdata);
         end
      end
      if (rst_n && rf_rd_write && rf_rd_waddr == 5'd0) x0_writes++;
   end

   function automatic logic [4:0] pick_noise(input logic [4:0] a, input logic [4:0] b);
      logic [4:0] n;
      do n = 5'($urandom_range(1, 31)); while (n == a || n == b);
      return n;
   endfunction

   task automatic dec_noise();
      dec_rs1_read  = 1'($urandom_range(0, 1));
      dec_rs1_raddr = 5'($urandom_range(0, 31));
      dec_rs2_read  = 1'($urandom_range(0, 1));
      dec_rs2_raddr = 5'($urandom_range(0, 31));
   endtask

   // Called just after a rising edge; returns at the falling edge of the ack cycle.
   task automatic do_txn(input bit wr, input logic [4:0] addr, input logic [31:0] wdata,
                         input int busy, input bit to, input bit late,
                         input logic [4:0] late_addr, input logic [31:0] late_data,
                         input bit drop_acc);
      exp_t e;
      int cyc, lat, exp_lat, access_cyc;
      logic [4:0] na;
      if (late && !to) golden[late_addr] = late_data;
      if (to) begin
         e = '{1'b1, 32'h0};
      end else if (wr) begin
         e = '{1'b0, 32'h0};
         if (addr != 5'd0) golden[addr] = wdata;
      end else begin
         e = '{1'b0, golden[addr]};
      end
      exp_q.push_back(e);
      access_cyc = busy + 2;
      dbg_bus.dbg_req   = 1'b1;
      dbg_bus.dbg_write = wr;
      dbg_bus.dbg_addr  = addr;
      dbg_bus.dbg_wdata = wdata;
      wb_rd_write = 1'b0;
      dec_noise();
      cyc = 0;
      lat = -1;
      while (lat < 0 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         wb_rd_write = 1'b0;
         pipe_busy   = to;
         dec_noise();
         if (to || cyc <= busy) begin
            // Each drain cycle is kept busy either by the pipeline or by a writeback.
            if (!to && $urandom_range(0, 1) == 0) pipe_busy = 1'b1;
            if (!pipe_busy || $urandom_range(0, 1) == 0) begin
               na = pick_noise(addr, late ? late_addr : addr);
               wb_rd_write = 1'b1;
               wb_rd_waddr = na;
               wb_rd_wdata = $urandom;
               golden[na]  = wb_rd_wdata;
            end
         end
         if (!to && late && cyc == access_cyc) begin
            wb_rd_write = 1'b1;
            wb_rd_waddr = late_addr;
            wb_rd_wdata = late_data;
         end
         if (!to && drop_acc && cyc == access_cyc) dbg_bus.dbg_req = 1'b0;
         @(negedge clk);
         if (dbg_bus.dbg_ack) lat = cyc;
      end
      exp_lat = to ? TIMEOUT + 1 : busy + 3 + (late ? 1 : 0);
      check("ack_latency", 32'(lat), 32'(exp_lat));
   endtask

   task automatic finish_txn(input bit b2b);
      @(posedge clk); #1;
      check("hold_release", {31'd0, pipe_hold}, 32'd0);
      if (!b2b) begin
         dbg_bus.dbg_req = 1'b0;
         pipe_busy   = 1'b0;
         wb_rd_write = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      pipe_busy = 1'b0;
      dec_rs1_read = 1'b0; dec_rs1_raddr = 5'd0;
      dec_rs2_read = 1'b0; dec_rs2_raddr = 5'd0;
      wb_rd_write = 1'b0; wb_rd_waddr = 5'd0; wb_rd_wdata = 32'h0;
      dbg_bus.dbg_req = 1'b0; dbg_bus.dbg_write = 1'b0;
      dbg_bus.dbg_addr = 5'd0; dbg_bus.dbg_wdata = 32'h0;
      for (int i = 0; i < 32; i++) golden[i] = init_val(i);

      repeat (3) @(posedge clk);
      #1;
      check("rst_pipe_hold", {31'd0, pipe_hold}, 32'd0);
      check("rst_ack", {31'd0, dbg_bus.dbg_ack}, 32'd0);
      check("rst_err", {31'd0, dbg_bus.dbg_err}, 32'd0);
      check("rst_rdata", dbg_bus.dbg_rdata, 32'd0);
      mem_init = 1'b0;
      rst_n = 1'b1;

      // Idle pass-through
      @(posedge clk); #1;
      dec_rs1_read = 1'b1; dec_rs1_raddr = 5'd5;
      wb_rd_write = 1'b1; wb_rd_waddr = 5'd7; wb_rd_wdata = 32'h1234;
      golden[7] = 32'h1234;
      #1;
      check("idle_rs1_read", {31'd0, rf_rs1_read}, 32'd1);
      check("idle_rs1_raddr", {27'd0, rf_rs1_raddr}, 32'd5);
      check("idle_rd_write", {31'd0, rf_rd_write}, 32'd1);
      check("idle_rd_waddr", {27'd0, rf_rd_waddr}, 32'd7);
      check("idle_rd_wdata", rf_rd_wdata, 32'h1234);
      check("idle_pipe_hold", {31'd0, pipe_hold}, 32'd0);
      @(posedge clk); #1;
      wb_rd_waddr = 5'd10; wb_rd_wdata = 32'hDEADBEEF;
      golden[10] = 32'hDEADBEEF;
      @(posedge clk); #1;
      wb_rd_write = 1'b0; dec_rs1_read = 1'b0;

      // Fast debug read, x0 write, drain timeout, late writeback ahead of a debug write
      do_txn(1'b0, 5'd10, 32'h0, 0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      finish_txn(1'b0);
      do_txn(1'b1, 5'd0, 32'hFFFFFFFF, 0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      finish_txn(1'b0);
      check("x0_not_written", 32'(x0_writes), 32'd0);
      do_txn(1'b0, 5'd12, 32'h0, 0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0);
      finish_txn(1'b0);
      do_txn(1'b1, 5'd3, 32'hCAFE0003, 0, 1'b0, 1'b1, 5'd3, 32'h0BAD0003, 1'b0);
      finish_txn(1'b0);
      do_txn(1'b0, 5'd3, 32'h0, 0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      finish_txn(1'b0);

      // Request withdrawn during DRAIN: no ack, no write
      dbg_bus.dbg_req = 1'b1; dbg_bus.dbg_write = 1'b1;
      dbg_bus.dbg_addr = 5'd15; dbg_bus.dbg_wdata = 32'h5555_5555;
      pipe_busy = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      dbg_bus.dbg_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      pipe_busy = 1'b0;
      check("drop_pipe_hold", {31'd0, pipe_hold}, 32'd0);

      // Reset during ACCESS abandons the pending write
      dbg_bus.dbg_req = 1'b1; dbg_bus.dbg_write = 1'b1;
      dbg_bus.dbg_addr = 5'd20; dbg_bus.dbg_wdata = 32'h7777_7777;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("access_rd_write", {31'd0, rf_rd_write}, 32'd1);
      check("access_rd_waddr", {27'd0, rf_rd_waddr}, 32'd20);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_hold", {31'd0, pipe_hold}, 32'd0);
      check("rst_mid_ack", {31'd0, dbg_bus.dbg_ack}, 32'd0);
      check("rst_mid_rd_write", {31'd0, rf_rd_write}, 32'd0);
      check("rst_mid_rdata", dbg_bus.dbg_rdata, 32'd0);
      dbg_bus.dbg_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_hold", {31'd0, pipe_hold}, 32'd0);
      do_txn(1'b0, 5'd20, 32'h0, 0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      finish_txn(1'b0);
      do_txn(1'b0, 5'd15, 32'h0, 1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
      finish_txn(1'b0);

      // Randomised traffic
      for (int t = 0; t < 40; t++) begin
         bit wr, to, late, drop, b2b;
         logic [4:0] addr, laddr;
         int busy;
         wr    = 1'($urandom_range(0, 1));
         addr  = 5'($urandom_range(0, 31));
         to    = ($urandom_range(0, 9) == 0);
         busy  = $urandom_range(0, 2);
         late  = ($urandom_range(0, 3) == 0);
         laddr = ($urandom_range(0, 1) == 0) ? addr : 5'($urandom_range(1, 31));
         if (laddr == 5'd0) laddr = 5'd1;
         drop  = ($urandom_range(0, 4) == 0);
         b2b   = ($urandom_range(0, 2) == 0);
         do_txn(wr, addr, $urandom, busy, to, late, laddr, $urandom, drop);
         finish_txn(b2b);
      end
      for (int a = 1; a < 32; a += 5) begin
         do_txn(1'b0, 5'(a), 32'h0, 0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
         finish_txn(1'b0);
      end

      repeat (3) @(posedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("x0_never_written", 32'(x0_writes), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
